// File: rtl/mcycle_sequencer.sv
`default_nettype none
// ============================================================================
// mcycle_sequencer : M-cycle/T-state sequencer with bus strobes, wait
//                    stretching and HALT/STOP low-power control.  Rev 1.0
// ============================================================================
module mcycle_sequencer #(
  parameter int TSTATES    = 4,
  parameter int WAIT_MAX   = 15,
  parameter int OSC_CYCLES = 16
) (
  input  logic               CLK,
  input  logic               SYNC_RESET,
  input  logic               BUS_REQ,
  input  logic               BUS_WR,
  input  logic               WAIT,
  input  logic               HALT_REQ,
  input  logic               STOP_REQ,
  input  logic               IRQ_PEND,
  input  logic               WAKE,
  input  logic               OSC_STABLE,
  output logic [TSTATES-1:0] T,
  output logic               M_END,
  output logic               MREQ,
  output logic               RD,
  output logic               WR,
  output logic               BUS_ERR,
  output logic               CLK_ENA,
  output logic               OSC_ENA,
  output logic [1:0]         STATE
);

  localparam int TW = (TSTATES > 1) ? $clog2(TSTATES) : 1;
  localparam int WW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam int OW = (OSC_CYCLES > 1) ? $clog2(OSC_CYCLES) : 1;

  localparam logic [TW-1:0]      T_LAST = TW'(TSTATES - 1);
  localparam logic [TW-1:0]      T_WAIT = TW'(TSTATES - 2);
  localparam logic [WW-1:0]      W_MAX  = WW'(WAIT_MAX);
  localparam logic [OW-1:0]      O_LAST = OW'(OSC_CYCLES - 1);
  localparam logic [TSTATES-1:0] T_ONE  = TSTATES'(1);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_HALT = 2'd1,
    S_STOP = 2'd2,
    S_OSC  = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [WW-1:0] wait_cnt, wait_cnt_n;
  logic [OW-1:0] osc_cnt, osc_cnt_n;
  logic          bus_act, bus_act_n;
  logic          bus_wr, bus_wr_n;
  logic          bus_err, bus_err_n;
  logic          run;
  logic          m_end;

  assign run   = (state == S_RUN);
  assign m_end = run && (tcnt == T_LAST);

  always_ff @(posedge CLK) begin
    if (SYNC_RESET) begin
      state    <= S_RUN;
      tcnt     <= '0;
      wait_cnt <= '0;
      osc_cnt  <= '0;
      bus_act  <= 1'b0;
      bus_wr   <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      state    <= state_n;
      tcnt     <= tcnt_n;
      wait_cnt <= wait_cnt_n;
      osc_cnt  <= osc_cnt_n;
      bus_act  <= bus_act_n;
      bus_wr   <= bus_wr_n;
      bus_err  <= bus_err_n;
    end
  end

  always_comb begin
    state_n    = state;
    tcnt_n     = tcnt;
    wait_cnt_n = wait_cnt;
    osc_cnt_n  = osc_cnt;
    bus_act_n  = bus_act;
    bus_wr_n   = bus_wr;
    bus_err_n  = 1'b0;

    case (state)
      S_RUN: begin
        if ((tcnt == T_WAIT) && bus_act && WAIT) begin
          // Stretch the cycle; at the limit force it to complete and flag it.
          if (wait_cnt == W_MAX) begin
            bus_err_n  = 1'b1;
            tcnt_n     = tcnt + TW'(1);
            wait_cnt_n = '0;
          end else begin
            wait_cnt_n = wait_cnt + WW'(1);
          end
        end else begin
          tcnt_n     = (tcnt == T_LAST) ? '0 : tcnt + TW'(1);
          wait_cnt_n = '0;
        end

        if (m_end) begin
          bus_act_n = BUS_REQ;
          bus_wr_n  = BUS_WR;
          if (STOP_REQ) begin
            state_n   = S_STOP;
            tcnt_n    = '0;
            bus_act_n = 1'b0;
          end else if (HALT_REQ) begin
            state_n   = S_HALT;
            tcnt_n    = '0;
            bus_act_n = 1'b0;
          end
        end
      end

      S_HALT: begin
        tcnt_n = '0;
        if (IRQ_PEND) begin
          state_n = S_RUN;
        end
      end

      S_STOP: begin
        tcnt_n = '0;
        if (WAKE) begin
          state_n   = S_OSC;
          osc_cnt_n = '0;
        end
      end

      S_OSC: begin
        tcnt_n = '0;
        if ((osc_cnt == O_LAST) && OSC_STABLE) begin
          state_n = S_RUN;
        end else if (osc_cnt != O_LAST) begin
          osc_cnt_n = osc_cnt + OW'(1);
        end
      end

      default: begin
        state_n = S_RUN;
        tcnt_n  = '0;
      end
    endcase
  end

  assign T       = run ? (T_ONE << tcnt) : '0;
  assign M_END   = m_end;
  assign MREQ    = run && bus_act;
  assign RD      = run && bus_act && !bus_wr;
  assign WR      = run && bus_act && bus_wr && (tcnt != '0) && (tcnt != T_LAST);
  assign BUS_ERR = bus_err;
  assign CLK_ENA = (state == S_RUN) || (state == S_HALT);
  assign OSC_ENA = (state != S_STOP);
  assign STATE   = state;

endmodule
`default_nettype wire

// File: tb/tb_mcycle_sequencer.sv
`default_nettype none
// Scoreboard bench: stimulus pushes hand-derived per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_mcycle_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bus_req = 0, bus_wr = 0, wait_in = 0, halt_req = 0, stop_req = 0;
  logic       irq_pend = 0, wake = 0, osc_stable = 0;
  logic [3:0] t;
  logic       m_end, mreq, rd, wr, bus_err, clk_ena, osc_ena;
  logic [1:0] state;

  typedef struct {
    string       name;
    logic [12:0] vec;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  mcycle_sequencer #(.TSTATES(4), .WAIT_MAX(15), .OSC_CYCLES(16)) dut (
    .CLK(clk), .SYNC_RESET(rst), .BUS_REQ(bus_req), .BUS_WR(bus_wr),
    .WAIT(wait_in), .HALT_REQ(halt_req), .STOP_REQ(stop_req),
    .IRQ_PEND(irq_pend), .WAKE(wake), .OSC_STABLE(osc_stable),
    .T(t), .M_END(m_end), .MREQ(mreq), .RD(rd), .WR(wr), .BUS_ERR(bus_err),
    .CLK_ENA(clk_ena), .OSC_ENA(osc_ena), .STATE(state)
  );

  always #5 clk = ~clk;

  // Push the expectation for the current cycle, then move to the next one.
  task automatic cyc(input string name, input logic [3:0] et, input logic em,
                     input logic emq, input logic erd, input logic ewr,
                     input logic eerr, input logic ecke, input logic eoe,
                     input logic [1:0] est);
    exp_t e;
    e.name = name;
    e.vec  = {et, em, emq, erd, ewr, eerr, ecke, eoe, est};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Plain RUN-state cycle at T-index i.
  task automatic run_cyc(input string name, input int i, input logic emq,
                         input logic erd, input logic ewr, input logic eerr);
    cyc(name, 4'(1 << i), (i == 3), emq, erd, ewr, eerr, 1'b1, 1'b1, 2'd0);
  endtask

  initial begin : monitor
    exp_t        e;
    logic [12:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        act = {t, m_end, mreq, rd, wr, bus_err, clk_ena, osc_ena, state};
        checks++;
        if (act !== e.vec) begin
          failures++;
          $display("FAIL %s @%0t: got T=%b M_END=%b MREQ=%b RD=%b WR=%b ERR=%b CKE=%b OE=%b ST=%0d, want %b_%b%b%b%b_%b_%b%b_%0d",
                   e.name, $time, t, m_end, mreq, rd, wr, bus_err, clk_ena, osc_ena, state,
                   e.vec[12:9], e.vec[8], e.vec[7], e.vec[6], e.vec[5], e.vec[4],
                   e.vec[3], e.vec[2], e.vec[1:0]);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle: T walks, no strobes.
    for (int i = 0; i < 8; i++) run_cyc("idle", i % 4, 0, 0, 0, 0);

    // Request a write at M_END.
    for (int i = 0; i < 3; i++) run_cyc("pre_wr", i, 0, 0, 0, 0);
    bus_req = 1; bus_wr = 1;
    run_cyc("wr_req", 3, 0, 0, 0, 0);
    bus_req = 0; bus_wr = 0;
    for (int i = 0; i < 3; i++) run_cyc("wr_cyc", i, 1, 0, (i == 1 || i == 2), 0);
    // Request a read at the end of the write cycle.
    bus_req = 1;
    run_cyc("wr_end", 3, 1, 0, 0, 0);
    bus_req = 0;

    // Read with three wait states at T=4.
    run_cyc("rd_t1", 0, 1, 1, 0, 0);
    run_cyc("rd_t2", 1, 1, 1, 0, 0);
    wait_in = 1;
    for (int i = 0; i < 3; i++) run_cyc("rd_wait", 2, 1, 1, 0, 0);
    wait_in = 0;
    run_cyc("rd_release", 2, 1, 1, 0, 0);
    bus_req = 1;
    run_cyc("rd_end", 3, 1, 1, 0, 0);
    bus_req = 0;

    // Read with WAIT stuck: 16 clocks at T=4, then forced release with BUS_ERR.
    wait_in = 1;
    run_cyc("to_t1", 0, 1, 1, 0, 0);
    run_cyc("to_t2", 1, 1, 1, 0, 0);
    for (int i = 0; i < 16; i++) run_cyc("to_hold", 2, 1, 1, 0, 0);
    run_cyc("to_err", 3, 1, 1, 0, 1);

    // WAIT with no bus access is ignored.
    for (int i = 0; i < 4; i++) run_cyc("wait_idle", i, 0, 0, 0, 0);
    wait_in = 0;

    // STOP beats HALT; BUS_REQ in the same slot is discarded.
    for (int i = 0; i < 3; i++) run_cyc("pre_stop", i, 0, 0, 0, 0);
    halt_req = 1; stop_req = 1; bus_req = 1;
    run_cyc("stop_req", 3, 0, 0, 0, 0);
    halt_req = 0; stop_req = 0; bus_req = 0;
    irq_pend = 1; osc_stable = 1;
    for (int i = 0; i < 3; i++) cyc("stop_irq", 4'd0, 0, 0, 0, 0, 0, 0, 0, 2'd2);
    irq_pend = 0;
    wake = 1;
    cyc("stop_wake", 4'd0, 0, 0, 0, 0, 0, 0, 0, 2'd2);
    wake = 0;
    for (int i = 0; i < 16; i++) cyc("osc_wait", 4'd0, 0, 0, 0, 0, 0, 0, 1, 2'd3);
    osc_stable = 0;
    run_cyc("osc_exit", 0, 0, 0, 0, 0);

    // HALT with interrupt already pending: exactly one clock.
    run_cyc("pre_halt", 1, 0, 0, 0, 0);
    run_cyc("pre_halt", 2, 0, 0, 0, 0);
    halt_req = 1; irq_pend = 1;
    run_cyc("halt_req", 3, 0, 0, 0, 0);
    halt_req = 0;
    cyc("halt_one", 4'd0, 0, 0, 0, 0, 0, 1, 1, 2'd1);
    irq_pend = 0;
    for (int i = 0; i < 3; i++) run_cyc("halt_exit", i, 0, 0, 0, 0);

    // HALT without interrupt; WAKE ignored; reset aborts it.
    halt_req = 1;
    run_cyc("halt2_req", 3, 0, 0, 0, 0);
    halt_req = 0; wake = 1;
    for (int i = 0; i < 3; i++) cyc("halt_hold", 4'd0, 0, 0, 0, 0, 0, 1, 1, 2'd1);
    wake = 0; rst = 1;
    cyc("halt_rst", 4'd0, 0, 0, 0, 0, 0, 1, 1, 2'd1);
    rst = 0;
    for (int i = 0; i < 4; i++) run_cyc("post_rst", i, 0, 0, 0, 0);

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
